alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Clocked front-end that issues requests to the 32-bit combinational gate-level ALU and returns registered results.
- Accepts one operation (op, a, b) per valid/ready handshake and drives the ALU input ports from registers.
- Waits a fixed settle window, because the ALU's gate delays make ripple carry multi-cycle, then captures the result and overflow.
- Returns the response on a second valid/ready handshake; this is the requesting side of the ALU interface.

Parameters:
- WIDTH, 32: operand/result width; must match the ALU (fixed 32 in this design).
- SETTLE_CYCLES, 4: clock cycles the ALU inputs are held before capture; legal range 1..15; a value of 0 is treated as 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  3  operation code.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  WIDTH  captured ALU result.
- rsp_overflow  output  1  captured overflow, masked to ADD/SUB.
- rsp_zero  output  1  rsp_result equals 0.
- alu_operation  output  3  to ALU operation input.
- alu_a  output  WIDTH  to ALU operand A.
- alu_b  output  WIDTH  to ALU operand B.
- alu_out  input  WIDTH  from ALU result.
- alu_overflow  input  1  from ALU overflow.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Opcodes (decided): ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7. The block does not decode them except for overflow masking.
- Reset (synchronous): at the edge where reset is high, state goes to IDLE. All of the following become 0: alu_operation/alu_a/alu_b, the settle counter, rsp_result, rsp_overflow, rsp_zero, rsp_valid, busy.
- req_ready = (state==IDLE) and not reset, so it reads 0 in any cycle where reset is high.
- The FSM has three states:
  - IDLE: req_ready=1. On req_valid and req_ready at edge E0:
    - register req_op/req_a/req_b onto alu_operation/alu_a/alu_b;
    - counter <= SETTLE_CYCLES-1;
    - go to SETTLE.
    - Without a request, alu_* hold their previous values.
  - SETTLE: req_ready=0 and alu_* are held stable.
    - If counter != 0: counter decrements each edge.
    - If counter == 0 at edge E0+SETTLE_CYCLES:
      - rsp_result <= alu_out;
      - rsp_zero <= (alu_out==0);
      - rsp_overflow <= alu_overflow and (alu_operation is 0 or 1);
      - rsp_valid <= 1;
      - go to RESP.
  - RESP: rsp_valid=1; rsp_* and alu_* are held stable until rsp_ready. On rsp_valid and rsp_ready: rsp_valid <= 0 and go to IDLE.
- Latency and throughput:
  - rsp_valid is first seen in the cycle after edge E0+SETTLE_CYCLES.
  - Minimum issue interval is SETTLE_CYCLES+2 cycles.
  - No overlap: a request is never accepted in the same cycle as a response handshake.
- Request-side rules:
  - Requester may hold req_valid high indefinitely; req_* are sampled only on the accepting edge.
  - Changes to req_* while in SETTLE/RESP have no effect.
- Response-side rules:
  - rsp_ready held high in IDLE/SETTLE has no effect.
  - rsp_ready held low in RESP stalls the block indefinitely with outputs stable.
- Reset mid-operation (SETTLE or RESP): the operation is abandoned, no response is produced, and all outputs go to their reset values at that edge.
- Simultaneous events: reset has priority over every handshake. req_valid arriving in the same cycle that RESP completes is accepted no earlier than the following IDLE cycle.
- Arithmetic: the block performs none. All results come from the ALU, sampled only at the capture edge.

Test Plan:
- ADD, a=5, b=7, SETTLE_CYCLES=4, rsp_ready=1 -> accepted at E0; rsp_valid in the cycle after E0+4; rsp_result=12, rsp_overflow=0, rsp_zero=0; busy low again one cycle later.
- SUB, a=0x7FFFFFFF, b=0xFFFFFFFF -> rsp_result=0x80000000, rsp_overflow=1.
- SUB, a=0x12345678, b=0x12345678 -> rsp_result=0, rsp_zero=1, rsp_overflow=0.
- Masking check with a stub ALU: AND op, stub forces alu_overflow=1, alu_out=0x0F -> rsp_overflow=0 and rsp_result=0x0F.
- Backpressure:
  - stimulus: SLT, a=0xFFFFFFFF (-1), b=1; second request waiting; rsp_ready held 0 for 10 cycles;
  - rsp_result=1 held stable throughout; req_ready=0 throughout;
  - second request accepted exactly one cycle after the response handshake.
- Reset mid-operation: reset pulsed for 1 cycle at E0+2 during SETTLE -> no rsp_valid ever for that operation; alu_a=0; req_ready=1 in the cycle after reset deasserts; next ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Clocked requester for the combinational gate-level ALU: latches one
// operation, holds the ALU inputs for a settle window so the ripple carry
// can propagate, then captures and returns the result over a handshake.
module alu_op_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic [2:0]       alu_operation,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  output logic             busy
);

  // A zero-length window would capture before the inputs reach the ALU.
  localparam int         SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [3:0] CNT_INIT   = 4'(SETTLE_EFF - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       req_fire;
  logic       capture;
  logic       rsp_fire;

  // Only the adder path produces a meaningful overflow; logic ops and SLT
  // may leave junk on the ALU's overflow pin.
  function automatic logic mask_overflow(input logic [2:0] op, input logic ovf);
    return ovf & ((op == OP_ADD) || (op == OP_SUB));
  endfunction

  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign req_fire  = req_valid && req_ready;
  assign capture   = (state == SETTLE) && (cnt == 4'd0);
  assign rsp_fire  = rsp_valid && rsp_ready;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = SETTLE;
      SETTLE:  if (capture)  state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand launch, settle countdown and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_operation <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      cnt           <= '0;
      rsp_result    <= '0;
      rsp_overflow  <= 1'b0;
      rsp_zero      <= 1'b0;
    end else begin
      if (req_fire) begin
        alu_operation <= req_op;
        alu_a         <= req_a;
        alu_b         <= req_b;
        cnt           <= CNT_INIT;
      end else if ((state == SETTLE) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_result   <= alu_out;
        rsp_zero     <= (alu_out == '0);
        rsp_overflow <= mask_overflow(alu_operation, alu_overflow);
      end
    end
  end

endmodule
